intersection_controller: RTL
============================

Name: intersection_controller

Overview:
- Sequences the signal heads of a two-road intersection: main road (default right-of-way) and side road, plus a pedestrian walk lamp for crossing the main road.
- Moore FSM with a shared dwell timer. Inserts yellow, all-red clearance and red+yellow prepare phases between greens.
- Grants the side road only on a vehicle sensor or pedestrian request.
- Drives the lamp outputs directly; sits above the per-head signal logic as its sequencer.

Parameters:
- CNT_W, 8, dwell counter width in bits.
- MAIN_MIN, 8, minimum main-green dwell in cycles.
- SIDE_GREEN, 6, fixed side-green dwell in cycles.
- YELLOW, 3, yellow dwell in cycles, both roads.
- ALL_RED, 2, all-red clearance dwell in cycles.
- RED_YELLOW, 2, red+yellow prepare dwell in cycles, both roads.
- Legal range for all durations: 1..2^CNT_W-1. Zero is illegal and not checked in RTL.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- side_sensor  input  1  side-road vehicle present; level or pulse, latched.
- ped_btn  input  1  pedestrian request; pulse, latched.
- main_red / main_yellow / main_green  output  1 each  main-road lamps.
- side_red / side_yellow / side_green  output  1 each  side-road lamps.
- ped_walk  output  1  walk lamp.
- phase  output  3  current state encoding, for debug.

Behaviour:
- States and encodings: MG=0, MY=1, AR1=2, SRY=3, SG=4, SY=5, AR2=6, MRY=7.
- Lamp decode per state, red/yellow/green as main;side:
  - MG: 001;100.
  - MY: 010;100.
  - AR1: 100;100.
  - SRY: 100;110.
  - SG: 100;001.
  - SY: 100;010.
  - AR2: 100;100.
  - MRY: 110;100.
- All outputs are a pure decode of the state register and flops. No combinational path from any input to any output.
- ped_walk = 1 only in SG, and only when walk_en is set.
- Dwell counter:
  - Clears to 0 on every state entry and increments each cycle.
  - A fixed-dwell state with duration D exits when cnt == D-1, so it is visible for exactly D cycles.
  - In MG the counter saturates at MAIN_MIN-1.
- Fixed sequence: MY -> AR1 -> SRY -> SG -> SY -> AR2 -> MRY -> MG.
- MG exit: leaves MG at the edge where cnt == MAIN_MIN-1 and (side_pend | ped_pend | side_sensor | ped_btn). MY is visible from the next cycle. With no request, MG holds indefinitely.
- Request latches:
  - side_pend is set by side_sensor in any state and cleared on entry to SRY.
  - ped_pend is set by ped_btn in any state and cleared on entry to SG. At that same edge, walk_en <= ped_pend | ped_btn.
  - walk_en clears on exit from SG.
  - Set has priority over clear in the same cycle: a request on the clearing edge stays pending and triggers the next cycle.
- Requests arriving during SRY..MRY are held. MG then still serves its full MAIN_MIN before the next side phase.
- Reset (asynchronous, any time, including mid-phase):
  - state=AR2, cnt=0, side_pend=ped_pend=walk_en=0.
  - Outputs go immediately to main_red=side_red=1, all other lamps=0, ped_walk=0, phase=6.
- After reset release: AR2 for ALL_RED cycles, then MRY for RED_YELLOW cycles, then MG.
- Safety invariants, checked by assertions:
  - Never main_green|main_yellow together with side_green|side_yellow.
  - Exactly one head is non-red outside the AR and RY states.
  - ped_walk implies main_red.

Test Plan:
- Reset release at cycle 0, defaults, no requests -> phase 6 for cycles 0-1, 7 for cycles 2-3, MG from cycle 4 and held for 100+ cycles; lamps match the decode throughout.
- side_sensor 1-cycle pulse at cycle 20 -> MY 21-23, AR1 24-25, SRY 26-27, SG 28-33 with ped_walk=0, SY 34-36, AR2 37-38, MRY 39-40, MG from 41.
- ped_btn pulse at cycle 5 (MG cnt=1) -> pend held; MY starts at cycle 12 (MAIN_MIN satisfied); SG with ped_walk=1 for all 6 cycles; ped_pend=0 afterwards.
- side_sensor pulse exactly on the SRY-entry edge -> side_pend remains 1; after return to MG, exactly MAIN_MIN=8 cycles of MG, then MY.
- rst asserted mid-SG (cnt=3) -> same-cycle outputs 100;100, ped_walk=0, phase=6; latches cleared; normal restart sequence follows.
- Random sensor/button stimulus for 10k cycles -> zero safety-assertion failures; every side request is served within 8+3+2+2+3+2+2+2=24 cycles of MG entry.

Source files
------------

// File: rtl/intersection_controller_if.sv
// Signal bundle between the intersection sequencer and the outside world:
// the two request inputs, the six vehicle lamps, the walk lamp and the
// debug phase code. The controller side is the master; whatever drives
// the sensors and observes the lamps uses the slave view.
interface intersection_controller_if;
    logic       side_sensor;
    logic       ped_btn;
    logic       main_red;
    logic       main_yellow;
    logic       main_green;
    logic       side_red;
    logic       side_yellow;
    logic       side_green;
    logic       ped_walk;
    logic [2:0] phase;

    modport master (
        input  side_sensor,
        input  ped_btn,
        output main_red,
        output main_yellow,
        output main_green,
        output side_red,
        output side_yellow,
        output side_green,
        output ped_walk,
        output phase
    );

    modport slave (
        output side_sensor,
        output ped_btn,
        input  main_red,
        input  main_yellow,
        input  main_green,
        input  side_red,
        input  side_yellow,
        input  side_green,
        input  ped_walk,
        input  phase
    );
endinterface

// File: rtl/intersection_controller.sv
// Two-road intersection sequencer. The main road holds green by default;
// a side-road vehicle or a pedestrian request sends the intersection
// through yellow, all-red and red+yellow phases into side green, then back.
// One dwell counter is shared by every phase and restarts on each entry.
// All lamp outputs decode registered state only, so nothing on the input
// side can glitch a lamp.
module intersection_controller #(
    parameter int CNT_W      = 8,
    parameter int MAIN_MIN   = 8,
    parameter int SIDE_GREEN = 6,
    parameter int YELLOW     = 3,
    parameter int ALL_RED    = 2,
    parameter int RED_YELLOW = 2
) (
    input logic                        clk,
    input logic                        rst,
    intersection_controller_if.master  bus_io
);

    // Phase codes; they are also what appears on the debug phase output,
    // and the sequence advances by counting up through them.
    localparam logic [2:0] ST_MG  = 3'd0;
    localparam logic [2:0] ST_MY  = 3'd1;
    localparam logic [2:0] ST_AR1 = 3'd2;
    localparam logic [2:0] ST_SRY = 3'd3;
    localparam logic [2:0] ST_SG  = 3'd4;
    localparam logic [2:0] ST_SY  = 3'd5;
    localparam logic [2:0] ST_AR2 = 3'd6;
    localparam logic [2:0] ST_MRY = 3'd7;

    // Last counter value of each dwell; a phase of length D ends at D-1.
    localparam logic [CNT_W-1:0] MG_LAST = CNT_W'(MAIN_MIN - 1);
    localparam logic [CNT_W-1:0] SG_LAST = CNT_W'(SIDE_GREEN - 1);
    localparam logic [CNT_W-1:0] Y_LAST  = CNT_W'(YELLOW - 1);
    localparam logic [CNT_W-1:0] AR_LAST = CNT_W'(ALL_RED - 1);
    localparam logic [CNT_W-1:0] RY_LAST = CNT_W'(RED_YELLOW - 1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             side_pend_q, side_pend_d;
    logic             ped_pend_q, ped_pend_d;
    logic             walk_en_q, walk_en_d;

    logic [CNT_W-1:0] dwell_last;
    logic             dwell_done;
    logic             any_req;
    logic             enter_sry;
    logic             enter_sg;
    logic             leave_sg;

    logic main_r, main_y, main_g;
    logic side_r, side_y, side_g;

    // Pick the terminal count for whichever phase is currently showing.
    always_comb begin
        dwell_last = MG_LAST;
        case (state_q)
            ST_MG:          dwell_last = MG_LAST;
            ST_MY, ST_SY:   dwell_last = Y_LAST;
            ST_AR1, ST_AR2: dwell_last = AR_LAST;
            ST_SRY, ST_MRY: dwell_last = RY_LAST;
            ST_SG:          dwell_last = SG_LAST;
            default:        dwell_last = MG_LAST;
        endcase
    end

    assign dwell_done = (cnt_q == dwell_last);

    // A request counts as soon as it is latched or is present this cycle,
    // so a single-cycle pulse arriving after the minimum is served at once.
    assign any_req = side_pend_q | ped_pend_q | bus_io.side_sensor | bus_io.ped_btn;

    // Next phase: every phase except main green advances on its dwell;
    // main green additionally waits for a request. Counting up wraps MRY to MG.
    always_comb begin
        state_d = state_q;
        if (dwell_done) begin
            if (state_q == ST_MG) begin
                if (any_req) begin
                    state_d = ST_MY;
                end
            end else begin
                state_d = state_q + 3'd1;
            end
        end
    end

    assign enter_sry = (state_d == ST_SRY) && (state_q != ST_SRY);
    assign enter_sg  = (state_d == ST_SG)  && (state_q != ST_SG);
    assign leave_sg  = (state_q == ST_SG)  && (state_d != ST_SG);

    // Dwell counter restarts on each phase change; the only phase that can
    // sit at its terminal count is main green, where it simply stops there.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (dwell_done) begin
            cnt_d = cnt_q;
        end
    end

    // Request latches: a new request wins over the clear on the same edge,
    // so nothing arriving exactly at the service point is lost.
    always_comb begin
        side_pend_d = bus_io.side_sensor | (side_pend_q & ~enter_sry);
        ped_pend_d  = bus_io.ped_btn     | (ped_pend_q  & ~enter_sg);
        walk_en_d   = walk_en_q;
        if (enter_sg) begin
            walk_en_d = ped_pend_q | bus_io.ped_btn;
        end else if (leave_sg) begin
            walk_en_d = 1'b0;
        end
    end

    // State register; reset parks in the all-red clearance before main green.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_AR2;
            cnt_q       <= '0;
            side_pend_q <= 1'b0;
            ped_pend_q  <= 1'b0;
            walk_en_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            side_pend_q <= side_pend_d;
            ped_pend_q  <= ped_pend_d;
            walk_en_q   <= walk_en_d;
        end
    end

    // Lamp decode from the phase register alone.
    always_comb begin
        main_r = 1'b1;
        main_y = 1'b0;
        main_g = 1'b0;
        side_r = 1'b1;
        side_y = 1'b0;
        side_g = 1'b0;
        case (state_q)
            ST_MG: begin
                main_r = 1'b0;
                main_g = 1'b1;
            end
            ST_MY: begin
                main_r = 1'b0;
                main_y = 1'b1;
            end
            ST_SRY: begin
                side_y = 1'b1;
            end
            ST_SG: begin
                side_r = 1'b0;
                side_g = 1'b1;
            end
            ST_SY: begin
                side_r = 1'b0;
                side_y = 1'b1;
            end
            ST_MRY: begin
                main_y = 1'b1;
            end
            default: begin
                main_r = 1'b1;
                side_r = 1'b1;
            end
        endcase
    end

    assign bus_io.main_red    = main_r;
    assign bus_io.main_yellow = main_y;
    assign bus_io.main_green  = main_g;
    assign bus_io.side_red    = side_r;
    assign bus_io.side_yellow = side_y;
    assign bus_io.side_green  = side_g;
    assign bus_io.ped_walk    = (state_q == ST_SG) & walk_en_q;
    assign bus_io.phase       = state_q;

endmodule
